sar_ctrl_sync: RTL and testbench

- Synchronous, parametrised successor to the ripple-clocked SAR code register.
- Runs the full successive-approximation sequence on one clock: sample phase, per-bit DAC trial, comparator strobe, decision capture.
- Result goes to a one-entry valid/ready output buffer.
- Adds runtime resolution select, continuous-conversion mode and overrun detection.
- Sits between the comparator / capacitive-DAC analog macro and the digital readout.

---
 rtl/sar_pkg.sv | 25 ++
 rtl/sar_out_buffer.sv | 36 +++
 rtl/sar_ctrl_sync.sv | 133 +++++++++++++
 tb/tb_sar_ctrl_sync.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and helpers for the synchronous SAR controller:
// FSM state encoding, width helpers and resolution clamping.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    DECIDE,
    DONE
  } sar_state_t;

  localparam int SAR_N_BITS = 8;

  // Width of a counter/index holding values 0..n-1, never narrower than 1 bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Zero or out-of-range resolution requests mean full resolution
  function automatic int eff_bits(input int res_cfg, input int n_bits);
    return ((res_cfg == 0) || (res_cfg > n_bits)) ? n_bits : res_cfg;
  endfunction

endpackage

// File: rtl/sar_out_buffer.sv
// One-entry valid/ready result register; drops a new result when still
// full and unread, flagging it with a one-cycle overrun pulse.
module sar_out_buffer #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N_BITS-1:0] din,
  input  logic              data_ready,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (!data_valid || data_ready) begin
          data_out   <= din;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sar_ctrl_sync.sv
// Single-clock successive-approximation controller: sample, per-bit DAC
// trial, comparator strobe and decision capture, feeding a result buffer.
module sar_ctrl_sync
  import sar_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cont,
  input  logic [$clog2(N_BITS+1)-1:0]  res_cfg,
  input  logic                         comparator_out,
  output logic                         sample,
  output logic                         comp_strobe,
  output logic [N_BITS-1:0]            dac_code,
  output logic                         busy,
  output logic [N_BITS-1:0]            data_out,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic                         overrun
);

  localparam int IDX_W   = clog2_min1(N_BITS);
  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = clog2_min1(CNT_MAX);

  sar_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] stop_idx;
  logic [CNT_W-1:0] cnt;

  // Lowest bit index to convert: resolution K is stored as N_BITS-K
  always_comb begin
    stop_idx = IDX_W'(N_BITS - eff_bits(int'(res_cfg), N_BITS));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sample      <= 1'b0;
      comp_strobe <= 1'b0;
      busy        <= 1'b0;
      dac_code    <= '0;
      idx         <= '0;
      last_idx    <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          dac_code <= '0;
          if (start) begin
            state    <= SAMPLE;
            sample   <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            last_idx <= stop_idx;
          end
        end
        SAMPLE: begin
          if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state              <= SETTLE;
            sample             <= 1'b0;
            cnt                <= '0;
            idx                <= IDX_W'(N_BITS - 1);
            dac_code           <= '0;
            dac_code[N_BITS-1] <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            state       <= DECIDE;
            comp_strobe <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECIDE: begin
          comp_strobe   <= 1'b0;
          dac_code[idx] <= comparator_out;
          // Later assignment to a different bit sets up the next trial
          if (idx > last_idx) begin
            idx                    <= idx - 1'b1;
            dac_code[idx - 1'b1]   <= 1'b1;
            state                  <= SETTLE;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          dac_code <= '0;
          cnt      <= '0;
          if (cont) begin
            state    <= SAMPLE;
            sample   <= 1'b1;
            last_idx <= stop_idx;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          sample      <= 1'b0;
          comp_strobe <= 1'b0;
          busy        <= 1'b0;
          dac_code    <= '0;
        end
      endcase
    end
  end

  // During DONE dac_code holds the finished code with unconverted LSBs at 0
  sar_out_buffer #(
    .N_BITS(N_BITS)
  ) u_out_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (state == DONE),
    .din        (dac_code),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_sar_ctrl_sync.sv
// Directed bench for sar_ctrl_sync with an ideal comparator model and a
// queue of expected conversion results.
module tb_sar_ctrl_sync;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] res_cfg;
  logic       comparator_out;
  logic       sample;
  logic       comp_strobe;
  logic [7:0] dac_code;
  logic       busy;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       overrun;

  logic [7:0] vin_code;
  logic [7:0] sb[$];
  int         tests;
  int         fails;

  logic [7:0] trials_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [7:0] trials [16];
  int         lat;
  int         strobes;

  sar_ctrl_sync #(
    .N_BITS        (8),
    .SAMPLE_CYCLES (2),
    .SETTLE_CYCLES (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cont           (cont),
    .res_cfg        (res_cfg),
    .comparator_out (comparator_out),
    .sample         (sample),
    .comp_strobe    (comp_strobe),
    .dac_code       (dac_code),
    .busy           (busy),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .overrun        (overrun)
  );

  assign comparator_out = (vin_code >= dac_code);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = 8'hxx;
    if (sb.size() > 0) e = sb.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, e);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] vin, input logic [3:0] cfg);
    int         k;
    logic [7:0] mask;
    k    = ((cfg == 0) || (cfg > 8)) ? 8 : int'(cfg);
    mask = 8'hFF << (8 - k);
    return vin & mask;
  endfunction

  // Start pulse is captured at edge 0; lat counts edges until data_valid
  task automatic wait_result();
    lat     = 0;
    strobes = 0;
    while (data_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (comp_strobe === 1'b1) begin
        if (strobes < 16) trials[strobes] = dac_code;
        strobes++;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_conv(input string tag, input logic [7:0] vin, input logic [3:0] cfg,
                          input int exp_lat, input int exp_strobes, input bit chk_trials);
    vin_code   = vin;
    res_cfg    = cfg;
    data_ready = 1'b1;
    cont       = 1'b0;
    sb.push_back(model(vin, cfg));
    pulse_start();
    wait_result();
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_strobes"}, strobes, exp_strobes);
    check_sb({tag, "_data"}, data_out);
    check({tag, "_busy_low"}, int'(busy), 0);
    if (chk_trials) begin
      for (int i = 0; i < 8; i++) check({tag, "_trial"}, int'(trials[i]), int'(trials_a5[i]));
    end
    @(posedge clk); #1;
    check({tag, "_valid_fall"}, int'(data_valid), 0);
    check({tag, "_data_hold"}, int'(data_out), int'(model(vin, cfg)));
  endtask

  initial begin
    int n;
    int busy_cycles;
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    cont       = 1'b0;
    res_cfg    = 4'd8;
    data_ready = 1'b0;
    vin_code   = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", int'(sample), 0);
    check("rst_strobe", int'(comp_strobe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_dac", int'(dac_code), 0);
    check("rst_data", int'(data_out), 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_conv("a5_k8", 8'hA5, 4'd8, 19, 8, 1'b1);
    run_conv("a5_k4", 8'hA5, 4'd4, 11, 4, 1'b0);
    run_conv("a5_k0", 8'hA5, 4'd0, 19, 8, 1'b0);
    run_conv("a5_k15", 8'hA5, 4'd15, 19, 8, 1'b0);
    run_conv("ones", 8'hFF, 4'd8, 19, 8, 1'b0);
    run_conv("zeros", 8'h00, 4'd8, 19, 8, 1'b0);

    // Continuous mode, consumer stalled: second result must be dropped
    data_ready = 1'b0;
    cont       = 1'b1;
    res_cfg    = 4'd8;
    vin_code   = 8'h3C;
    sb.push_back(8'h3C);
    pulse_start();
    wait_result();
    check("ovr_lat1", lat, 19);
    check_sb("ovr_data1", data_out);
    vin_code = 8'h77;
    cont     = 1'b0;
    n        = 0;
    while (overrun !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovr_pulse_time", n, 19);
    check("ovr_data_kept", int'(data_out), 8'h3C);
    check("ovr_valid", int'(data_valid), 1);
    @(posedge clk); #1;
    check("ovr_one_cycle", int'(overrun), 0);
    check("ovr_idle", int'(busy), 0);
    data_ready = 1'b1;
    @(posedge clk); #1;
    check("ovr_drain", int'(data_valid), 0);

    // Same, but the consumer reads on the second DONE edge
    data_ready = 1'b0;
    cont       = 1'b1;
    vin_code   = 8'h3C;
    sb.push_back(8'h3C);
    sb.push_back(8'h77);
    pulse_start();
    wait_result();
    check("rd_lat1", lat, 19);
    check_sb("rd_data1", data_out);
    vin_code = 8'h77;
    cont     = 1'b0;
    repeat (18) @(posedge clk);
    #1 data_ready = 1'b1;
    @(posedge clk); #1;
    check_sb("rd_data2", data_out);
    check("rd_valid2", int'(data_valid), 1);
    check("rd_no_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    check("rd_no_overrun_late", int'(overrun), 0);
    check("rd_valid_fall", int'(data_valid), 0);

    // Start held high across a conversion yields one result
    vin_code = 8'h5A;
    res_cfg  = 4'd8;
    sb.push_back(8'h5A);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (data_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 12) start = 1'b0;
    end
    check("hold_latency", lat, 19);
    check_sb("hold_data", data_out);
    busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) busy_cycles++;
    end
    check("hold_single", busy_cycles, 0);

    // Reset during the third DECIDE aborts everything at once
    vin_code = 8'hA5;
    pulse_start();
    strobes = 0;
    n       = 0;
    while (strobes < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (comp_strobe === 1'b1) strobes++;
    end
    check("abort_reached", strobes, 3);
    rst = 1'b0;
    #1;
    check("abort_sample", int'(sample), 0);
    check("abort_strobe", int'(comp_strobe), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(data_valid), 0);
    check("abort_overrun", int'(overrun), 0);
    check("abort_dac", int'(dac_code), 0);
    check("abort_data", int'(data_out), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_no_result", int'(data_valid), 0);
    run_conv("post_rst", 8'hA5, 4'd8, 19, 8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
